// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults, the NOP encoding and the
// fetch FSM state encoding used by the instruction-fetch stage.
package cpu_pkg;

    // Datapath width defaults shared with the PC module
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Instruction driven into decode whenever IF/ID holds no real instruction
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        HOLD  = ST_HOLD,
        DRAIN = ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter that measures how long a memory request has been
// outstanding. It raises terminal when the count reaches TIMEOUT-1.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign terminal = (count == TC);

    // Count enabled cycles, clear has priority, and stop at the terminal value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: accepts the next word address from the PC module,
// fetches it over a variable-latency req/ack memory handshake and places the
// instruction, its PC and PC+1 in the IF/ID register. Handles decode stalls
// (via a one-entry hold buffer), branch flushes (draining a request memory
// cannot cancel) and a sticky memory-timeout error.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
    parameter int                TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              fetch_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              flush,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_post_pc,
    output logic              fetch_err
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic              next_req;
    logic              accept;
    logic              load_fetch;
    logic              load_hold;
    logic              capture_hold;
    logic              set_err;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_tc;

    logic [DATA_W-1:0] hold_instr;
    logic [ADDR_W-1:0] hold_pc;

    assign fetch_ready = (state == IDLE) && !fetch_err;

    // The timer only runs while a request is outstanding and nothing came back
    assign timer_clear  = (state == IDLE) || (state == HOLD);
    assign timer_enable = ((state == REQ) || (state == DRAIN)) && !imem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_tc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control; ack beats timeout, timeout beats flush
    always_comb begin
        next_state   = state;
        next_req     = imem_req;
        accept       = 1'b0;
        load_fetch   = 1'b0;
        load_hold    = 1'b0;
        capture_hold = 1'b0;
        set_err      = 1'b0;
        case (state)
            IDLE: begin
                if (pc_valid && fetch_ready) begin
                    accept     = 1'b1;
                    next_req   = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    next_req   = 1'b0;
                    next_state = IDLE;
                    if (flush) begin
                        next_state = IDLE;
                    end else if (!id_stall || !ifid_valid) begin
                        load_fetch = 1'b1;
                    end else begin
                        capture_hold = 1'b1;
                        next_state   = HOLD;
                    end
                end else if (timer_tc) begin
                    set_err    = 1'b1;
                    next_req   = 1'b0;
                    next_state = IDLE;
                end else if (flush) begin
                    next_state = DRAIN;
                end
            end
            HOLD: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (!id_stall) begin
                    load_hold  = 1'b1;
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    next_req   = 1'b0;
                    next_state = IDLE;
                end else if (timer_tc) begin
                    set_err    = 1'b1;
                    next_req   = 1'b0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_req   = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Memory request interface and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            fetch_err <= 1'b0;
        end else begin
            imem_req <= next_req;
            if (accept) begin
                imem_addr <= pc_in;
            end
            if (set_err) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Hold buffer parks a fetched word while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (capture_hold) begin
            hold_instr <= imem_rdata;
            hold_pc    <= imem_addr;
        end
    end

    // IF/ID register: flush, then load, then stall-hold, otherwise a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_valid   <= 1'b0;
            ifid_instr   <= NOP_INSTR;
            ifid_pc      <= '0;
            ifid_post_pc <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (load_fetch) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= imem_rdata;
            ifid_pc      <= imem_addr;
            ifid_post_pc <= imem_addr + ADDR_W'(1);
        end else if (load_hold) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= hold_instr;
            ifid_pc      <= hold_pc;
            ifid_post_pc <= hold_pc + ADDR_W'(1);
        end else if (!id_stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Directed stimulus pushes the
// expected IF/ID contents into a queue; a monitor pops and compares whenever
// a new instruction appears in IF/ID. Control signals are checked directly.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        fetch_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_post_pc;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] post;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    logic prevValid = 1'b0;
    logic prevStall = 1'b0;

    instr_fetch_unit #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NOP_INSTR (32'h0000_0000),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .fetch_ready  (fetch_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .id_stall     (id_stall),
        .flush        (flush),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_post_pc (ifid_post_pc),
        .fetch_err    (fetch_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one value and count the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drive all DUT inputs at once
    task automatic applyStimulus(input logic [31:0] pc, input logic pv, input logic stall,
                                 input logic fl, input logic ack, input logic [31:0] rdata);
        pc_in      = pc;
        pc_valid   = pv;
        id_stall   = stall;
        flush      = fl;
        imem_ack   = ack;
        imem_rdata = rdata;
    endtask

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // New IF/ID content is any valid cycle not explained by a stalled hold
    always @(negedge clk) begin
        if (rst_n && ifid_valid && !(prevValid && prevStall)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ifid actual=0x%08h expected=none", ifid_instr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sb_instr", ifid_instr, monExp.instr);
                checkOutput("sb_pc", ifid_pc, monExp.pc);
                checkOutput("sb_post_pc", ifid_post_pc, monExp.post);
            end
        end
        prevValid = ifid_valid;
        prevStall = id_stall;
    end

    // Safety net in case the sequence below ever stops advancing
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        checkOutput("rst_ifid_instr", ifid_instr, 32'h0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd1);

        // Basic fetch with ack one cycle after the request
        $display("[TB] basic fetch");
        applyStimulus(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t1_req", 32'(imem_req), 32'd1);
        checkOutput("t1_addr", imem_addr, 32'h10);
        checkOutput("t1_ready_busy", 32'(fetch_ready), 32'd0);
        expQ.push_back('{instr: 32'h2001_0005, pc: 32'h10, post: 32'h11});
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2001_0005);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_valid", 32'(ifid_valid), 32'd1);
        checkOutput("t1_req_drop", 32'(imem_req), 32'd0);
        checkOutput("t1_ready", 32'(fetch_ready), 32'd1);

        // Stall: fetched word parks in the hold buffer, IF/ID unchanged
        $display("[TB] stall and release");
        applyStimulus(32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_ready_hold", 32'(fetch_ready), 32'd0);
        checkOutput("t2_instr_kept", ifid_instr, 32'h2001_0005);
        checkOutput("t2_pc_kept", ifid_pc, 32'h10);
        checkOutput("t2_req_drop", 32'(imem_req), 32'd0);
        tick();
        checkOutput("t2_instr_kept2", ifid_instr, 32'h2001_0005);
        expQ.push_back('{instr: 32'hAAAA_0001, pc: 32'h20, post: 32'h21});
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t2_instr_rel", ifid_instr, 32'hAAAA_0001);
        checkOutput("t2_ready_rel", 32'(fetch_ready), 32'd1);
        tick();
        checkOutput("t2_bubble_valid", 32'(ifid_valid), 32'd0);
        checkOutput("t2_bubble_instr", ifid_instr, 32'h0);

        // Flush while the request is in flight; late word is discarded
        $display("[TB] flush in flight");
        applyStimulus(32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_valid", 32'(ifid_valid), 32'd0);
        checkOutput("t3_req_held", 32'(imem_req), 32'd1);
        checkOutput("t3_ready_drain", 32'(fetch_ready), 32'd0);
        tick();
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_valid_after", 32'(ifid_valid), 32'd0);
        checkOutput("t3_ready_after", 32'(fetch_ready), 32'd1);
        checkOutput("t3_req_after", 32'(imem_req), 32'd0);

        // Flush and redirect in the same IDLE cycle
        $display("[TB] flush with redirect");
        applyStimulus(32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        expQ.push_back('{instr: 32'h1111_2222, pc: 32'h50, post: 32'h51});
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
        tick();
        applyStimulus(32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_valid_before", 32'(ifid_valid), 32'd1);
        tick();
        checkOutput("t4_valid_cleared", 32'(ifid_valid), 32'd0);
        checkOutput("t4_instr_nop", ifid_instr, 32'h0);
        checkOutput("t4_req", 32'(imem_req), 32'd1);
        checkOutput("t4_addr", imem_addr, 32'h40);
        expQ.push_back('{instr: 32'h3333_4444, pc: 32'h40, post: 32'h41});
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_4444);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_valid_new", 32'(ifid_valid), 32'd1);

        // Address wrap and a spurious ack while idle
        $display("[TB] wrap and spurious ack");
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        expQ.push_back('{instr: 32'h0BAD_F00D, pc: 32'hFFFF_FFFF, post: 32'h0});
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        checkOutput("t6_post_wrap", ifid_post_pc, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_spur_instr", ifid_instr, 32'h0BAD_F00D);
        checkOutput("t6_spur_req", 32'(imem_req), 32'd0);
        checkOutput("t6_spur_ready", 32'(fetch_ready), 32'd1);
        tick();

        // Timeout after 16 request cycles with no ack
        $display("[TB] timeout");
        applyStimulus(32'h60, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (15) tick();
        checkOutput("t5_req_15", 32'(imem_req), 32'd1);
        checkOutput("t5_err_15", 32'(fetch_err), 32'd0);
        tick();
        checkOutput("t5_err_16", 32'(fetch_err), 32'd1);
        checkOutput("t5_req_16", 32'(imem_req), 32'd0);
        checkOutput("t5_ready_16", 32'(fetch_ready), 32'd0);
        applyStimulus(32'h70, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t5_no_accept_req", 32'(imem_req), 32'd0);
        checkOutput("t5_no_accept_ready", 32'(fetch_ready), 32'd0);
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        checkOutput("t5_rst_err", 32'(fetch_err), 32'd0);
        checkOutput("t5_rst_req", 32'(imem_req), 32'd0);
        checkOutput("t5_rst_addr", imem_addr, 32'h0);
        checkOutput("t5_rst_valid", 32'(ifid_valid), 32'd0);
        checkOutput("t5_rst_instr", ifid_instr, 32'h0);
        checkOutput("t5_rst_pc", ifid_pc, 32'h0);
        checkOutput("t5_rst_post_pc", ifid_post_pc, 32'h0);
        checkOutput("t5_rst_ready", 32'(fetch_ready), 32'd1);

        tick();
        tick();
        checkOutput("sb_queue_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
